// File: rtl/simulador_drone_param_if.sv
// Player controls, obstacle ROM column and game status of the drone simulator.
// Latency: none, pure wiring.
// Backpressure: none, level/pulse signals only.
interface simulador_drone_param_if #(
    parameter int LARGURA = 16,
    parameter int ALTURA  = 8
);
    localparam int WH = $clog2(LARGURA);
    localparam int WV = $clog2(ALTURA);

    logic              iniciar;
    logic [1:0]        controle_vertical;
    logic [1:0]        controle_horizontal;
    logic              confirma;
    logic [ALTURA-1:0] obstaculos_coluna;
    logic [WH-1:0]     posicao_horizontal;
    logic [WV-1:0]     posicao_vertical;
    logic [2:0]        vidas;
    logic [2:0]        colisoes;
    logic [1:0]        modo;
    logic [3:0]        estado;
    logic              venceu;
    logic              perdeu;
    logic              timeout_out;

    modport master (
        output iniciar, controle_vertical, controle_horizontal, confirma, obstaculos_coluna,
        input  posicao_horizontal, posicao_vertical, vidas, colisoes, modo, estado,
               venceu, perdeu, timeout_out
    );

    modport slave (
        input  iniciar, controle_vertical, controle_horizontal, confirma, obstaculos_coluna,
        output posicao_horizontal, posicao_vertical, vidas, colisoes, modo, estado,
               venceu, perdeu, timeout_out
    );
endinterface

// File: rtl/simulador_drone_param.sv
// Drone grid game: moves on control edges, checks obstacles, tracks lives, win/lose/timeout.
// Latency: request edge at n -> new position at n+2 -> outcome state at n+3.
// Backpressure: none; control activity outside ESPERA is dropped, never queued.
module simulador_drone_param #(
    parameter int LARGURA        = 16,
    parameter int ALTURA         = 8,
    parameter int VIDAS_INI      = 3,
    parameter int TIMEOUT_CICLOS = 5000
) (
    input  logic clock,
    input  logic reset,
    simulador_drone_param_if.slave bus
);
    localparam int WH = $clog2(LARGURA);
    localparam int WV = $clog2(ALTURA);
    localparam int WT = $clog2(TIMEOUT_CICLOS);
    localparam logic [WH-1:0] H_MAX = WH'(LARGURA - 1);
    localparam logic [WV-1:0] V_MAX = WV'(ALTURA - 1);
    localparam logic [WT-1:0] T_MAX = WT'(TIMEOUT_CICLOS - 1);

    typedef enum logic [3:0] {
        IDLE         = 4'd0,
        ESCOLHE_MODO = 4'd1,
        PREPARA      = 4'd2,
        ESPERA       = 4'd3,
        MOVE         = 4'd4,
        CHECA        = 4'd5,
        COLISAO      = 4'd6,
        VENCEU       = 4'd7,
        PERDEU       = 4'd8
    } estado_t;

    estado_t       st;
    logic [WH-1:0] ph, ph_ant;
    logic [WV-1:0] pv, pv_ant;
    logic [2:0]    vidas_r, colisoes_r;
    logic [1:0]    modo_r;
    logic          venceu_r, perdeu_r, timeout_r;
    logic [WT-1:0] ocioso;
    logic          h_ant, v_ant, conf_ant;
    logic [1:0]    mov_h, mov_v;

    logic       h_ativo, v_ativo, req_h, req_v, conf_sobe, temporizado, bloqueado;
    logic [1:0] modo_sel;

    always_comb begin
        h_ativo     = (bus.controle_horizontal == 2'b01) || (bus.controle_horizontal == 2'b10);
        v_ativo     = (bus.controle_vertical == 2'b01) || (bus.controle_vertical == 2'b10);
        req_h       = h_ativo & ~h_ant;
        req_v       = v_ativo & ~v_ant;
        conf_sobe   = bus.confirma & ~conf_ant;
        modo_sel    = (bus.controle_horizontal == 2'b11) ? 2'b10 : bus.controle_horizontal;
        temporizado = (modo_r == 2'b01) || (modo_r == 2'b10);
        bloqueado   = bus.obstaculos_coluna[pv];
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            st         <= IDLE;
            ph         <= '0;
            pv         <= '0;
            ph_ant     <= '0;
            pv_ant     <= '0;
            vidas_r    <= '0;
            colisoes_r <= '0;
            modo_r     <= '0;
            venceu_r   <= 1'b0;
            perdeu_r   <= 1'b0;
            timeout_r  <= 1'b0;
            ocioso     <= '0;
            h_ant      <= 1'b0;
            v_ant      <= 1'b0;
            conf_ant   <= 1'b0;
            mov_h      <= '0;
            mov_v      <= '0;
        end else begin
            // Edge detectors run in every state so a control held through a
            // non-waiting state never fires as a fresh request later.
            h_ant    <= h_ativo;
            v_ant    <= v_ativo;
            conf_ant <= bus.confirma;
            case (st)
                IDLE: begin
                    if (bus.iniciar) begin
                        venceu_r   <= 1'b0;
                        perdeu_r   <= 1'b0;
                        timeout_r  <= 1'b0;
                        colisoes_r <= '0;
                        st         <= ESCOLHE_MODO;
                    end
                end
                ESCOLHE_MODO: begin
                    if (conf_sobe) begin
                        modo_r <= modo_sel;
                        st     <= PREPARA;
                    end
                end
                PREPARA: begin
                    ph      <= '0;
                    pv      <= '0;
                    vidas_r <= (modo_r == 2'b10) ? 3'd1 : 3'(VIDAS_INI);
                    ocioso  <= '0;
                    st      <= ESPERA;
                end
                ESPERA: begin
                    if (req_h || req_v) begin
                        mov_h <= req_h ? bus.controle_horizontal : 2'b00;
                        mov_v <= req_v ? bus.controle_vertical : 2'b00;
                        st    <= MOVE;
                    end else if (temporizado) begin
                        if (ocioso == T_MAX) begin
                            timeout_r <= 1'b1;
                            perdeu_r  <= 1'b1;
                            st        <= PERDEU;
                        end else begin
                            ocioso <= ocioso + WT'(1);
                        end
                    end
                end
                MOVE: begin
                    ph_ant <= ph;
                    pv_ant <= pv;
                    if (mov_h == 2'b01 && ph != H_MAX) ph <= ph + WH'(1);
                    else if (mov_h == 2'b10 && ph != '0) ph <= ph - WH'(1);
                    if (mov_v == 2'b01 && pv != V_MAX) pv <= pv + WV'(1);
                    else if (mov_v == 2'b10 && pv != '0) pv <= pv - WV'(1);
                    ocioso <= '0;
                    st     <= CHECA;
                end
                CHECA: begin
                    if (bloqueado) begin
                        st <= COLISAO;
                    end else if (ph == H_MAX) begin
                        venceu_r <= 1'b1;
                        st       <= VENCEU;
                    end else begin
                        st <= ESPERA;
                    end
                end
                COLISAO: begin
                    vidas_r <= (vidas_r != 3'd0) ? vidas_r - 3'd1 : 3'd0;
                    if (colisoes_r != 3'd7) colisoes_r <= colisoes_r + 3'd1;
                    ph <= ph_ant;
                    pv <= pv_ant;
                    if (vidas_r <= 3'd1) begin
                        perdeu_r <= 1'b1;
                        st       <= PERDEU;
                    end else begin
                        st <= ESPERA;
                    end
                end
                VENCEU, PERDEU: begin
                    if (bus.iniciar) begin
                        venceu_r  <= 1'b0;
                        perdeu_r  <= 1'b0;
                        timeout_r <= 1'b0;
                        st        <= ESCOLHE_MODO;
                    end
                end
                default: st <= IDLE;
            endcase
        end
    end

    assign bus.posicao_horizontal = ph;
    assign bus.posicao_vertical   = pv;
    assign bus.vidas              = vidas_r;
    assign bus.colisoes           = colisoes_r;
    assign bus.modo               = modo_r;
    assign bus.estado             = st;
    assign bus.venceu             = venceu_r;
    assign bus.perdeu             = perdeu_r;
    assign bus.timeout_out        = timeout_r;
endmodule

// File: doc/simulador_drone_param.md
SIMULADOR_DRONE_PARAM -- requirements
Module: simulador_drone_param

Interface
REQ-001 Parameters SHALL be: LARGURA, default 16, number of horizontal positions (columns, >=2); ALTURA, default 8, number of vertical positions (rows, >=2); VIDAS_INI, default 3, lives in modes 00/01 (1..7); TIMEOUT_CICLOS, default 5000, idle cycles allowed per move in timed modes (>=2).
REQ-002 Derived widths: WH=clog2(LARGURA), WV=clog2(ALTURA).
REQ-003 Ports, one per line (name direction width meaning):
 clock  in  1  single system clock, rising edge;
 reset  in  1  asynchronous, active-high;
 iniciar  in  1  level, starts a game from IDLE/VENCEU/PERDEU;
 controle_vertical  in  2  01=up, 10=down, 00/11=none;
 controle_horizontal  in  2  01=forward, 10=back, 00/11=none;
 confirma  in  1  raw level, edge-detected internally;
 obstaculos_coluna  in  ALTURA  obstacle mask of column posicao_horizontal, from external combinational ROM, bit i = row i blocked;
 posicao_horizontal  out  WH  current column, also ROM address;
 posicao_vertical  out  WV  current row;
 vidas  out  3  remaining lives;
 colisoes  out  3  collision count, saturates at 7;
 modo  out  2  latched game mode;
 estado  out  4  FSM state code;
 venceu, perdeu, timeout_out  out  1 each  sticky result flags.

Function
REQ-004 States and codes: IDLE=0, ESCOLHE_MODO=1, PREPARA=2, ESPERA=3, MOVE=4, CHECA=5, COLISAO=6, VENCEU=7, PERDEU=8; unused codes SHALL go to IDLE.
REQ-005 IDLE->ESCOLHE_MODO when iniciar=1; clears venceu, perdeu, timeout_out, colisoes.
REQ-006 ESCOLHE_MODO: on confirma rising edge, latch modo=controle_horizontal (11 treated as 10), go to PREPARA.
REQ-007 PREPARA (1 cycle): position=(0,0); vidas=1 if modo=10, else VIDAS_INI; idle counter=0; ->ESPERA.
REQ-008 Move request = rising edge (registered previous value) of "control != none" on either axis; horizontal and vertical requests in the same cycle SHALL both apply.
REQ-009 ESPERA: on request ->MOVE; in modes 01/10 the idle counter increments each ESPERA cycle, and on reaching TIMEOUT_CICLOS-1 timeout_out=1, ->PERDEU; mode 00 never times out.
REQ-010 MOVE (1 cycle): save previous position, apply move saturating at 0 and LARGURA-1 / ALTURA-1 (no wrap), idle counter=0; ->CHECA.
REQ-011 CHECA (1 cycle): sample obstaculos_coluna[posicao_vertical]; blocked ->COLISAO; else posicao_horizontal=LARGURA-1 ->VENCEU; else ->ESPERA.
REQ-012 COLISAO (1 cycle): vidas-=1, colisoes+=1 (saturate), restore saved position; if vidas was 1 ->PERDEU else ->ESPERA.
REQ-013 Latency: request edge at cycle n -> new position visible n+2 -> outcome state n+3.
REQ-014 VENCEU/PERDEU: set corresponding flag, hold all outputs; iniciar=1 ->ESCOLHE_MODO (flags cleared).
REQ-015 Control activity outside ESPERA SHALL be ignored (no queued moves).
REQ-016 A saturated move with no position change SHALL still pass CHECA and reset the idle counter.

Reset
REQ-017 reset=1 SHALL asynchronously force IDLE, positions 0, vidas 0, colisoes 0, modo 00, all flags 0, idle counter 0, edge-detector registers 0, independent of state, including mid-move.
REQ-018 After deassertion the block SHALL stay in IDLE until iniciar=1.

Verification (LARGURA=4, ALTURA=4, VIDAS_INI=3, TIMEOUT_CICLOS=8, empty map unless stated)
REQ-019 Win: mode 00, 3 forward pulses -> posicao_horizontal 1,2,3; venceu=1, estado=7, vidas=3.
REQ-020 Collision: mask col1=0001, forward at row 0 -> vidas 2, colisoes 1, position restored to (0,0), estado back to 3.
REQ-021 Lose on lives: mode 10, same obstacle -> vidas 0, perdeu=1, estado=8.
REQ-022 Timeout: mode 01, no input -> timeout_out=1, perdeu=1 exactly 8 cycles after entering ESPERA; mode 00 idle 100 cycles -> estado stays 3.
REQ-023 Saturation/diagonal: at (0,0) assert back+down -> position stays (0,0); assert forward+up -> (1,1) in one move.
REQ-024 Async reset mid-MOVE -> all outputs at reset values same cycle; held controls after release cause no move.
